// File: rtl/sobel_window_feeder.sv
// Sobel window feeder: turns a raster 8-bit pixel stream into 3x3 windows,
// hands each full window to the edge detector with a start pulse, waits for
// the done pulse (or a timeout) and returns the result on a valid/ready stream.
// Only one window is in flight at a time; pixel intake stalls meanwhile.
module sobel_window_feeder #(
  parameter int IMG_WIDTH      = 16,
  parameter int IMG_HEIGHT     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_pix_valid,
  input  logic [7:0] i_pix_data,
  input  logic       i_sof,
  output logic       o_pix_ready,
  output logic       o_gradient_start,
  output logic [7:0] o_P0,
  output logic [7:0] o_P1,
  output logic [7:0] o_P2,
  output logic [7:0] o_P3,
  output logic [7:0] o_P4,
  output logic [7:0] o_P5,
  output logic [7:0] o_P6,
  output logic [7:0] o_P7,
  output logic [7:0] o_P8,
  input  logic       i_gradient_data_ready,
  input  logic [7:0] i_processed_sum,
  output logic       o_out_valid,
  output logic [7:0] o_out_data,
  input  logic       i_out_ready,
  output logic       o_frame_done,
  output logic       o_timeout_err
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_ACCEPT, ST_START, ST_WAIT, ST_EMIT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             last_q, last_d;          // in-flight window is the frame's last
  logic [TW-1:0]    timer_q, timer_d;
  logic [8:0][7:0]  win_q, win_d;            // index 0 = P0 ... index 8 = P8
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             start_q, start_d;
  logic             frame_done_q, frame_done_d;
  logic             timeout_err_q, timeout_err_d;

  logic [7:0]       lb0 [IMG_WIDTH];         // previous line
  logic [7:0]       lb1 [IMG_WIDTH];         // line before previous

  logic             accept;
  logic [CW-1:0]    col_eff;
  logic [RW-1:0]    row_eff;
  logic [7:0]       top_pix, mid_pix;

  // An sof-qualified pixel is always treated as row 0 / column 0.
  assign accept  = i_pix_valid && (state_q == ST_ACCEPT);
  assign col_eff = i_sof ? '0 : col_q;
  assign row_eff = i_sof ? '0 : row_q;
  assign top_pix = lb1[col_eff];
  assign mid_pix = lb0[col_eff];

  // Next-state, position counters, window shift and result capture.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    last_d        = last_q;
    timer_d       = timer_q;
    win_d         = win_q;
    out_data_d    = out_data_q;
    timeout_err_d = timeout_err_q;
    frame_done_d  = 1'b0;

    unique case (state_q)
      ST_ACCEPT: begin
        if (accept) begin
          win_d[0] = win_q[1];  win_d[1] = win_q[2];  win_d[2] = top_pix;
          win_d[3] = win_q[4];  win_d[4] = win_q[5];  win_d[5] = mid_pix;
          win_d[6] = win_q[7];  win_d[7] = win_q[8];  win_d[8] = i_pix_data;
          if (i_sof) timeout_err_d = 1'b0;
          last_d = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
          if (col_eff != COL_LAST) begin
            col_d = col_eff + CW'(1);
            row_d = row_eff;
          end else if (row_eff != ROW_LAST) begin
            col_d = '0;
            row_d = row_eff + RW'(1);
          end else begin
            // Last pixel: position is held until its result has been taken.
            col_d = col_eff;
            row_d = row_eff;
          end
          if ((row_eff >= RW'(2)) && (col_eff >= CW'(2))) state_d = ST_START;
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_gradient_data_ready) begin
          out_data_d = i_processed_sum;
          state_d    = ST_EMIT;
        end else if (timer_q == TIMER_LAST) begin
          out_data_d    = 8'h00;
          timeout_err_d = 1'b1;
          state_d       = ST_EMIT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_EMIT: begin
        if (i_out_ready) begin
          state_d = ST_ACCEPT;
          if (last_q) begin
            frame_done_d = 1'b1;
            col_d        = '0;
            row_d        = '0;
            last_d       = 1'b0;
          end
        end
      end
      default: state_d = ST_ACCEPT;
    endcase

    out_valid_d = (state_d == ST_EMIT);
    start_d     = (state_d == ST_START);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_ACCEPT;
      col_q         <= '0;
      row_q         <= '0;
      last_q        <= 1'b0;
      timer_q       <= '0;
      win_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'h00;
      start_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      last_q        <= last_d;
      timer_q       <= timer_d;
      win_q         <= win_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      start_q       <= start_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Line buffers: move the column down one line and store the new pixel.
  // NOTE: RAM is deliberately left unreset; stale lines are never used because windows need row>=2.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_eff] <= mid_pix;
      lb0[col_eff] <= i_pix_data;
    end
  end

  assign o_pix_ready      = (state_q == ST_ACCEPT);
  assign o_gradient_start = start_q;
  assign o_out_valid      = out_valid_q;
  assign o_out_data       = out_data_q;
  assign o_frame_done     = frame_done_q;
  assign o_timeout_err    = timeout_err_q;
  assign o_P0 = win_q[0];
  assign o_P1 = win_q[1];
  assign o_P2 = win_q[2];
  assign o_P3 = win_q[3];
  assign o_P4 = win_q[4];
  assign o_P5 = win_q[5];
  assign o_P6 = win_q[6];
  assign o_P7 = win_q[7];
  assign o_P8 = win_q[8];

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Bench for sobel_window_feeder: a frame-level reference (pixel image array,
// raster position, window extraction, Sobel magnitude) plus a detector model
// that answers start pulses after a programmable latency.
module tb_sobel_window_feeder;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int TO = 32;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       i_pix_valid, i_sof, i_out_ready;
  logic [7:0] i_pix_data;
  logic       i_gradient_data_ready;
  logic [7:0] i_processed_sum;
  logic       o_pix_ready, o_gradient_start, o_out_valid, o_frame_done, o_timeout_err;
  logic [7:0] o_out_data;
  logic [7:0] o_P0, o_P1, o_P2, o_P3, o_P4, o_P5, o_P6, o_P7, o_P8;
  logic [8:0][7:0] dut_w;

  assign dut_w = {o_P8, o_P7, o_P6, o_P5, o_P4, o_P3, o_P2, o_P1, o_P0};

  sobel_window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .i_sof(i_sof),
    .o_pix_ready(o_pix_ready), .o_gradient_start(o_gradient_start),
    .o_P0(o_P0), .o_P1(o_P1), .o_P2(o_P2), .o_P3(o_P3), .o_P4(o_P4),
    .o_P5(o_P5), .o_P6(o_P6), .o_P7(o_P7), .o_P8(o_P8),
    .i_gradient_data_ready(i_gradient_data_ready), .i_processed_sum(i_processed_sum),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready),
    .o_frame_done(o_frame_done), .o_timeout_err(o_timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Detector model controls: 0 = constant answer, 1 = Sobel magnitude, 2 = never answers.
  int         det_mode = 1;
  logic [7:0] det_val  = 8'h00;
  int         det_lat  = 5;
  int         start_count = 0;

  // Reference state.
  logic [7:0] img [H][W];
  int         k = 0;                 // raster index of the next pixel
  logic       exp_err = 1'b0;
  int         bp_fixed = -1;         // -1: random backpressure length
  logic [7:0] res_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sobel(input logic [8:0][7:0] w);
    int gx, gy, s;
    gx = (int'(w[2]) + 2 * int'(w[5]) + int'(w[8])) - (int'(w[0]) + 2 * int'(w[3]) + int'(w[6]));
    gy = (int'(w[6]) + 2 * int'(w[7]) + int'(w[8])) - (int'(w[0]) + 2 * int'(w[1]) + int'(w[2]));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    s = gx + gy;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  // Detector model: answers each start pulse det_lat cycles later.
  initial begin : detector
    int cnt;
    logic [7:0] res;
    cnt = -1;
    res = 8'h00;
    i_gradient_data_ready = 1'b0;
    i_processed_sum = 8'h00;
    forever begin
      @(posedge clk); #1;
      i_gradient_data_ready = 1'b0;
      if (!n_rst) begin
        cnt = -1;
      end else if (o_gradient_start) begin
        start_count++;
        if (det_mode != 2) begin
          cnt = det_lat;
          res = (det_mode == 0) ? det_val : sobel(dut_w);
        end
      end else if (cnt > 0) begin
        cnt--;
      end
      if (cnt == 0) begin
        i_gradient_data_ready = 1'b1;
        i_processed_sum = res;
        cnt = -1;
      end
    end
  end

  // Wait for the result of the window just started, apply backpressure, take it.
  task automatic collect(input logic [8:0][7:0] exp_w, input bit is_last);
    int n, nb, exp_lat;
    logic [7:0] exp_d;
    exp_d   = (det_mode == 0) ? det_val : (det_mode == 1) ? sobel(exp_w) : 8'h00;
    exp_lat = (det_mode == 2) ? TO + 1 : det_lat + 1;
    n = 0;
    while (!o_out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check("start_one_cycle", o_gradient_start, 1'b0);
    end
    if (det_mode == 2) exp_err = 1'b1;
    check("out_valid_rise", o_out_valid, 1'b1);
    check("result_latency", n, exp_lat);
    check("out_data", o_out_data, exp_d);
    check("timeout_err", o_timeout_err, exp_err);
    nb = (bp_fixed >= 0) ? bp_fixed : int'($urandom_range(0, 3));
    for (int i = 0; i < nb; i++) begin
      i_out_ready = 1'b0;
      @(posedge clk); #1;
      check("bp_valid", o_out_valid, 1'b1);
      check("bp_data", o_out_data, exp_d);
      check("bp_pix_ready", o_pix_ready, 1'b0);
      check("bp_no_start", o_gradient_start, 1'b0);
    end
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    check("valid_drop", o_out_valid, 1'b0);
    check("frame_done", o_frame_done, is_last);
    check("pix_ready_back", o_pix_ready, 1'b1);
    res_q.push_back(exp_d);
    if (is_last) begin
      @(posedge clk); #1;
      check("frame_done_pulse", o_frame_done, 1'b0);
    end
  endtask

  // Offer one pixel, check the window decision and optionally take the result.
  task automatic push(input logic [7:0] pix, input logic sof, input bit take_result);
    int n, r, c;
    bit is_last;
    logic [8:0][7:0] exp_w;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    i_pix_valid = 1'b1;
    i_pix_data  = pix;
    i_sof       = sof;
    n = 0;
    while (!o_pix_ready && n < 200) begin @(posedge clk); #1; n++; end
    check("pix_ready", o_pix_ready, 1'b1);
    @(posedge clk); #1;
    i_pix_valid = 1'b0;
    i_sof       = 1'b0;
    if (sof) begin k = 0; exp_err = 1'b0; end
    r = k / W;
    c = k % W;
    img[r][c] = pix;
    is_last = (k == W * H - 1);
    k = is_last ? 0 : k + 1;
    check("timeout_err_acc", o_timeout_err, exp_err);
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 9; i++) exp_w[i] = img[r - 2 + i / 3][c - 2 + i % 3];
      check("start", o_gradient_start, 1'b1);
      check("pix_ready_busy", o_pix_ready, 1'b0);
      for (int i = 0; i < 9; i++) check($sformatf("P%0d", i), dut_w[i], exp_w[i]);
      if (take_result) collect(exp_w, is_last);
    end else begin
      check("no_start", o_gradient_start, 1'b0);
      check("pix_ready_idle", o_pix_ready, 1'b1);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int s0, seen;
    i_pix_valid = 1'b0; i_pix_data = 8'h00; i_sof = 1'b0; i_out_ready = 1'b0;
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_ready", o_pix_ready, 1'b1);
    check("rst_start", o_gradient_start, 1'b0);
    check("rst_valid", o_out_valid, 1'b0);
    check("rst_data", o_out_data, 8'h00);
    check("rst_frame_done", o_frame_done, 1'b0);
    check("rst_timeout_err", o_timeout_err, 1'b0);
    check("rst_window", dut_w, 72'h0);
    n_rst = 1'b1;

    // Reset while a window is waiting for the detector.
    det_mode = 2;
    for (int p = 0; p <= 10; p++) push(8'(p + 100), p == 0, 1'b0);
    repeat (5) @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    check("mid_rst_pix_ready", o_pix_ready, 1'b1);
    check("mid_rst_start", o_gradient_start, 1'b0);
    check("mid_rst_valid", o_out_valid, 1'b0);
    check("mid_rst_data", o_out_data, 8'h00);
    check("mid_rst_frame_done", o_frame_done, 1'b0);
    check("mid_rst_err", o_timeout_err, 1'b0);
    check("mid_rst_window", dut_w, 72'h0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    k = 0;
    exp_err = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (o_gradient_start || o_out_valid) seen++;
    end
    check("no_activity_after_rst", seen, 0);

    // 4x4 ramp, constant detector answer 8'hAB after 20 cycles.
    det_mode = 0; det_val = 8'hAB; det_lat = 20;
    s0 = start_count;
    res_q.delete();
    for (int p = 0; p < 16; p++) push(8'(p), p == 0, 1'b1);
    check("ramp_starts", start_count - s0, 4);

    // Long backpressure on every result.
    det_mode = 1; bp_fixed = 10;
    for (int p = 0; p < 16; p++) push(8'($urandom), p == 0, 1'b1);
    bp_fixed = -1;

    // Timeout on the first window, later windows answered; next sof clears the error.
    det_mode = 2;
    for (int p = 0; p <= 10; p++) push(8'($urandom), p == 0, 1'b1);
    det_mode = 1; det_lat = 3;
    for (int p = 11; p < 16; p++) push(8'($urandom), 1'b0, 1'b1);
    push(8'h11, 1'b1, 1'b1);
    for (int p = 1; p < 16; p++) push(8'($urandom), 1'b0, 1'b1);

    // Resync: sof arrives at row 1 col 3 of the current frame.
    s0 = start_count;
    for (int p = 0; p < 7; p++) push(8'($urandom), p == 0, 1'b1);
    push(8'h42, 1'b1, 1'b1);
    for (int p = 1; p < 10; p++) push(8'($urandom), 1'b0, 1'b1);
    check("resync_no_early_start", start_count - s0, 0);
    for (int p = 10; p < 16; p++) push(8'($urandom), 1'b0, 1'b1);
    check("resync_starts", start_count - s0, 4);

    // Sobel detector on fixed images.
    res_q.delete();
    for (int p = 0; p < 16; p++) push(8'(p), p == 0, 1'b1);
    check("sobel_ramp_first", res_q[0], 8'd40);
    res_q.delete();
    for (int p = 0; p < 16; p++) push(8'd77, p == 0, 1'b1);
    check("sobel_flat_first", res_q[0], 8'd0);
    res_q.delete();
    for (int p = 0; p < 16; p++) push((p % W) >= 2 ? 8'd255 : 8'd0, p == 0, 1'b1);
    check("sobel_step_first", res_q[0], 8'd255);

    // Randomized frames: pixels, gaps, latency, backpressure and stray sof.
    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < 16; p++) begin
        det_lat = $urandom_range(1, TO - 1);
        push(8'($urandom), (p == 0) || ($urandom_range(0, 19) == 0), 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
